// File: rtl/booth_pp_accum.sv
// Radix-4 Booth partial-product accumulator: sums PP_NUM shifted partial products into a 2*LENGTH product.
// Optional macro BOOTH_ACC_B2B_EN: lets the next operation's first partial product overlap the product handshake.
module booth_pp_accum #(
  parameter int LENGTH = 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [LENGTH+1:0]             pp_i,
  input  logic                          pp_valid_i,
  output logic                          pp_ready_o,
  output logic [2*LENGTH-1:0]           product_o,
  output logic                          prod_valid_o,
  input  logic                          prod_ready_i,
  output logic [$clog2(LENGTH/2)-1:0]   pp_idx_o
);

  localparam int PP_NUM = LENGTH / 2;
  localparam int IDX_W  = $clog2(PP_NUM);
  localparam int PW     = 2 * LENGTH;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PP_NUM - 1);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    acc;
  logic [IDX_W-1:0] idx;

  logic [PW-1:0]    pp_ext;
  logic [PW-1:0]    term;
  logic [PW-1:0]    acc_nxt;
  logic             pp_xfer;
  logic             prod_xfer;
  logic             idx_last;

  // Booth partial products are signed; widen before shifting into place.
  assign pp_ext   = {{(PW-LENGTH-2){pp_i[LENGTH+1]}}, pp_i};
  assign term     = pp_ext << {idx, 1'b0};
  assign acc_nxt  = (idx == '0) ? term : acc + term;
  assign idx_last = (idx == IDX_LAST);

  always_comb begin
    pp_ready_o = 1'b0;
    case (state)
      ACC:  pp_ready_o = 1'b1;
`ifdef BOOTH_ACC_B2B_EN
      DONE: pp_ready_o = prod_ready_i;
`else
      DONE: pp_ready_o = 1'b0;
`endif
      default: pp_ready_o = 1'b0;
    endcase
  end

  assign pp_xfer      = pp_valid_i && pp_ready_o;
  assign prod_xfer    = (state == DONE) && prod_ready_i;
  assign prod_valid_o = (state == DONE);
  assign product_o    = acc;
  assign pp_idx_o     = idx;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= ACC;
      acc   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        ACC: begin
          if (pp_xfer) begin
            acc <= acc_nxt;
            if (idx_last) begin
              idx   <= '0;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (prod_xfer) begin
            state <= ACC;
            // idx is 0 here, so acc_nxt is the fresh load of the next operation's first term.
            if (pp_xfer) begin
              acc <= acc_nxt;
              idx <= IDX_W'(1);
            end
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: doc/booth_pp_accum.md
BOOTH_PP_ACCUM -- requirements
Module: booth_pp_accum

Interface
REQ-001 SHALL have parameter LENGTH, default 8, meaning multiplicand/multiplier width; even, >=4.
REQ-002 SHALL have parameter derived PP_NUM = LENGTH/2, meaning partial products per operation; local, not overridable.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port sys_rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port pp_i, input, LENGTH+2, signed two's-complement partial product from the Booth encoder stage.
REQ-006 SHALL have port pp_valid_i, input, 1, pp_i valid.
REQ-007 SHALL have port pp_ready_o, output, 1, block can accept pp_i.
REQ-008 SHALL have port product_o, output, 2*LENGTH, signed product.
REQ-009 SHALL have port prod_valid_o, output, 1, product_o valid.
REQ-010 SHALL have port prod_ready_i, input, 1, consumer accepts product_o.
REQ-011 SHALL have port pp_idx_o, output, clog2(PP_NUM), index of next expected partial product.

Function
REQ-012 SHALL implement FSM with states ACC and DONE only.
REQ-013 In ACC: pp_ready_o=1, prod_valid_o=0.
REQ-014 A pp transfer SHALL occur on a rising edge with pp_valid_i=1 and pp_ready_o=1; no transfer otherwise, accumulator and index unchanged.
REQ-015 On transfer: acc <= acc + (sign-extend(pp_i) to 2*LENGTH) << (2*pp_idx_o), modulo 2^(2*LENGTH); pp_idx_o increments.
REQ-016 The first pp of an operation (pp_idx_o=0) SHALL load acc with the shifted term, not add to the old value.
REQ-017 Transfer with pp_idx_o=PP_NUM-1 SHALL wrap pp_idx_o to 0 and move to DONE next cycle.
REQ-018 In DONE: prod_valid_o=1, product_o=acc, stable until handshake; pp_ready_o=0 (except REQ-024).
REQ-019 Product handshake on a rising edge with prod_valid_o=1 and prod_ready_i=1 SHALL return to ACC.
REQ-020 Latency: product_o valid the cycle after the last pp transfer; no internal bubbles between pp transfers.
REQ-021 prod_ready_i held low SHALL hold DONE indefinitely, product_o unchanged, pp_valid_i ignored.
REQ-022 pp_i changes while pp_valid_i=0 SHALL have no effect.

Reset
REQ-023 With sys_rst_n=0 at a rising edge: state=ACC, acc=0, pp_idx_o=0, prod_valid_o=0, product_o=0, pp_ready_o=1 after release; reset mid-operation SHALL discard partial accumulation with no product emitted.

Configuration
REQ-024 Macro BOOTH_ACC_B2B_EN defined: in DONE, pp_ready_o=prod_ready_i; a simultaneous product handshake and pp transfer SHALL start the next operation (REQ-016 load, pp_idx_o=1) in the same edge, giving zero-bubble back-to-back throughput of one product per PP_NUM cycles.
REQ-025 Macro BOOTH_ACC_B2B_EN undefined: pp_ready_o=0 throughout DONE; one idle cycle between operations; throughput one product per PP_NUM+1 cycles.

Verification (LENGTH=8)
REQ-026 7*5: pp_i 10'h007,10'h007,10'h000,10'h000 on consecutive cycles, prod_ready_i=1 -> product_o=16'h0023, prod_valid_o high one cycle after 4th transfer.
REQ-027 -1*1: pp_i 10'h3FF,10'h000,10'h000,10'h000 -> product_o=16'hFFFF.
REQ-028 Backpressure: after REQ-026 sequence, prod_ready_i low 3 cycles with pp_valid_i=1 -> product_o stays 16'h0023, pp_ready_o=0, pp_idx_o=0, no pp consumed.
REQ-029 Gapped input: pp_valid_i toggled 1,0,1,0,1,1,... with REQ-026 values -> same 16'h0023, acc unaffected by gap cycles.
REQ-030 Reset mid-op: two pp transfers, sys_rst_n=0 one cycle -> pp_idx_o=0, prod_valid_o=0, product_o=0; following REQ-027 sequence yields 16'hFFFF.
REQ-031 Back-to-back: REQ-026 then REQ-027 streamed continuously with prod_ready_i=1 -> with BOOTH_ACC_B2B_EN products 16'h0023, 16'hFFFF 4 cycles apart; without, 5 cycles apart.
